dec_addr_sequencer: RTL and testbench

DEC_ADDR_SEQUENCER -- requirements
Module: dec_addr_sequencer

---
 rtl/dec_addr_sequencer_pkg.sv | 28 ++
 rtl/dwell_cnt.sv | 39 +++
 rtl/dec_addr_sequencer.sv | 157 +++++++++++++++
 tb/tb_dec_addr_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_addr_sequencer_pkg.sv
// ============================================================================
// Module   : dec_addr_sequencer_pkg
// Brief    : Shared state encodings, index width and index limits for the
//            decoder address sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_addr_sequencer_pkg;

  localparam int                 c_idx_w   = 6;
  localparam logic [c_idx_w-1:0] c_idx_min = 6'd0;
  localparam logic [c_idx_w-1:0] c_idx_max = 6'd63;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_SINGLE = 2'd2
  } seq_state_t;

  function automatic logic [c_idx_w-1:0] step_idx(input logic [c_idx_w-1:0] idx,
                                                  input logic               down);
    return down ? (idx - 6'd1) : (idx + 6'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dwell_cnt.sv
// ============================================================================
// Module   : dwell_cnt
// Brief    : Dwell counter; counts 0..limit and flags the terminal count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_cnt #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               term
);

  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_limit;

  // The limit is captured on load so later changes on the input are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (load) begin
      r_cnt   <= '0;
      r_limit <= limit;
    end else if (en) begin
      r_cnt <= term ? '0 : (r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1});
    end
  end

  assign term = (r_cnt == r_limit);

endmodule

`default_nettype wire

// File: rtl/dec_addr_sequencer.sv
// ============================================================================
// Module   : dec_addr_sequencer
// Brief    : Drives En/w of a 6-to-64 decoder with full scans or single shots.
//            Optional macro SEQ_DOWN_EN adds a dir input for descending scans.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_addr_sequencer
  import dec_addr_sequencer_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
`ifdef SEQ_DOWN_EN
  input  logic               dir,
`endif
  input  logic [DWELL_W-1:0] dwell,
  input  logic [c_idx_w-1:0] idx_in,
  input  logic               idx_valid,
  output logic               idx_ready,
  output logic               En,
  output logic [c_idx_w-1:0] w,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  seq_state_t         r_state, w_state_nxt;
  logic               r_en, w_en_nxt;
  logic [c_idx_w-1:0] r_idx, w_idx_nxt;
  logic               r_loop, w_loop_nxt;
  logic               r_down, w_down_nxt;
  logic               r_done, w_done_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               w_load;
  logic               w_term;
  logic               w_start_down;
  logic [c_idx_w-1:0] w_first;
  logic [c_idx_w-1:0] w_last;

`ifdef SEQ_DOWN_EN
  assign w_start_down = dir;
`else
  assign w_start_down = 1'b0;
`endif

  assign w_first = r_down ? c_idx_max : c_idx_min;
  assign w_last  = r_down ? c_idx_min : c_idx_max;

  dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .en    (busy),
    .limit (dwell),
    .term  (w_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_en    <= 1'b0;
      r_idx   <= c_idx_min;
      r_loop  <= 1'b0;
      r_down  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_idx   <= w_idx_nxt;
      r_loop  <= w_loop_nxt;
      r_down  <= w_down_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_idx_nxt   = r_idx;
    w_loop_nxt  = r_loop;
    w_down_nxt  = r_down;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_en_nxt    = 1'b1;
          w_idx_nxt   = w_start_down ? c_idx_max : c_idx_min;
          w_loop_nxt  = loop;
          w_down_nxt  = w_start_down;
          w_load      = 1'b1;
        end else if (idx_valid) begin
          w_state_nxt = ST_SINGLE;
          w_en_nxt    = 1'b1;
          w_idx_nxt   = idx_in;
          w_load      = 1'b1;
        end
      end
      ST_SCAN: begin
        // Abort outranks the dwell boundary: no done or wrap on stop.
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
        end else if (w_term) begin
          if (r_idx == w_last) begin
            if (r_loop) begin
              w_idx_nxt  = w_first;
              w_wrap_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_en_nxt    = 1'b0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_idx_nxt = step_idx(r_idx, r_down);
          end
        end
      end
      ST_SINGLE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
        end else if (w_term) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign idx_ready = (r_state == ST_IDLE) && !start;
  assign En        = r_en;
  assign w         = r_idx;
  assign done      = r_done;
  assign wrap      = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_dec_addr_sequencer.sv
// ============================================================================
// Module   : tb_dec_addr_sequencer
// Brief    : Self-checking bench for dec_addr_sequencer (SEQ_DOWN_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, loop, dir, idx_valid;
  logic [3:0] dwell;
  logic [5:0] idx_in;
  logic       idx_ready, En, busy, done, wrap;
  logic [5:0] w;

  always #5 clk = ~clk;

  dec_addr_sequencer #(.DWELL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
`ifdef SEQ_DOWN_EN
    .dir       (dir),
`endif
    .dwell     (dwell),
    .idx_in    (idx_in),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .En        (En),
    .w         (w),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  typedef struct packed {
    logic       en;
    logic [5:0] w;
    logic       done;
    logic       wrap;
    logic       busy;
  } obs_t;

  typedef struct {
    bit       scan;
    bit [5:0] idx;
    bit [3:0] dw;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(logic en, logic [5:0] idx, logic dn, logic wr, logic bz);
    return {en, idx, dn, wr, bz};
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = {En, w, done, wrap, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got en=%b w=%0d done=%b wrap=%b busy=%b, expected en=%b w=%0d done=%b wrap=%b busy=%b",
               name, $time, act.en, act.w, act.done, act.wrap, act.busy,
               exp.en, exp.w, exp.done, exp.wrap, exp.busy);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic push_hold(input logic [5:0] idx, input int n, input bit wrap_first);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, idx, 1'b0, wrap_first && (i == 0), 1'b1));
  endtask

  task automatic push_single(input logic [5:0] idx, input int dw);
    push_hold(idx, dw + 1, 1'b0);
    exp_q.push_back(mk(1'b0, idx, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, idx, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_pass(input int dw, input bit down, input bit wrap_first);
    for (int k = 0; k < 64; k++) begin
      logic [5:0] idx;
      idx = down ? 6'(63 - k) : 6'(k);
      push_hold(idx, dw + 1, wrap_first && (k == 0));
    end
  endtask

  task automatic push_scan_once(input int dw, input bit down);
    logic [5:0] last;
    last = down ? 6'd0 : 6'd63;
    push_pass(dw, down, 1'b0);
    exp_q.push_back(mk(1'b0, last, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, last, 0, 0, 0));
  endtask

  // Each cycle pops one expectation; while busy, sampled-at-start inputs are
  // scrambled and stray start/idx_valid pulses are thrown at the DUT.
  task automatic run_q(input string name);
    obs_t e;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      idx_valid = 1'b0;
      e = exp_q.pop_front();
      check_obs(name, e);
      check_bit({name, "_ready"}, idx_ready, !e.busy);
      if (e.busy) begin
        dwell     = 4'($urandom);
        loop      = 1'($urandom);
        dir       = 1'($urandom);
        idx_in    = 6'($urandom);
        start     = ($urandom_range(0, 7) == 0);
        idx_valid = ($urandom_range(0, 7) == 0);
      end
    end
    start     = 1'b0;
    idx_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{scan: 1'b0, idx: 6'd37, dw: 4'd2};
    vecs[1] = '{scan: 1'b1, idx: 6'd0,  dw: 4'd0};
    vecs[2] = '{scan: 1'b0, idx: 6'd0,  dw: 4'd0};
    vecs[3] = '{scan: 1'b0, idx: 6'd63, dw: 4'd15};
    vecs[4] = '{scan: 1'b1, idx: 6'd0,  dw: 4'd2};
    vecs[5] = '{scan: 1'b0, idx: 6'd5,  dw: 4'd1};
    vecs[6] = '{scan: 1'b0, idx: 6'd12, dw: 4'd3};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; dir = 1'b0;
    idx_valid = 1'b0; dwell = 4'd0; idx_in = 6'd0;
    #1;
    check_obs("reset_async", mk(0, 6'd0, 0, 0, 0));
    check_bit("reset_ready", idx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_held", mk(0, 6'd0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_obs("post_reset_idle", mk(0, 6'd0, 0, 0, 0));

    // Stop while idle has no effect.
    stop = 1'b1;
    exp_q.push_back(mk(0, 6'd0, 0, 0, 0));
    run_q("stop_idle");
    stop = 1'b0;

    for (int i = 0; i < 7; i++) begin
      dwell = vecs[i].dw; loop = 1'b0; dir = 1'b0;
      if (vecs[i].scan) begin
        start = 1'b1;
        push_scan_once(int'(vecs[i].dw), 1'b0);
      end else begin
        idx_in = vecs[i].idx; idx_valid = 1'b1;
        #1;
        check_bit("vec_ready", idx_ready, 1'b1);
        push_single(vecs[i].idx, int'(vecs[i].dw));
      end
      run_q($sformatf("vec%0d", i));
    end

    // start and idx_valid together: scan wins, idx_in ignored.
    start = 1'b1; idx_valid = 1'b1; idx_in = 6'd50; dwell = 4'd0; loop = 1'b0; dir = 1'b0;
    #1;
    check_bit("both_ready", idx_ready, 1'b0);
    push_scan_once(0, 1'b0);
    run_q("start_wins");

    // Looping scan: wrap after 64 cycles, then stop at w=20.
    start = 1'b1; dwell = 4'd0; loop = 1'b1; dir = 1'b0;
    push_pass(0, 1'b0, 1'b0);
    for (int k = 0; k <= 20; k++) exp_q.push_back(mk(1, 6'(k), 0, (k == 0), 1));
    run_q("loop_scan");
    stop = 1'b1;
    exp_q.push_back(mk(0, 6'd20, 0, 0, 0));
    exp_q.push_back(mk(0, 6'd20, 0, 0, 0));
    run_q("loop_stop");
    stop = 1'b0;

    // Stop during a single shot.
    idx_valid = 1'b1; idx_in = 6'd9; dwell = 4'd7;
    push_hold(6'd9, 3, 1'b0);
    run_q("single_run");
    stop = 1'b1;
    exp_q.push_back(mk(0, 6'd9, 0, 0, 0));
    run_q("single_stop");
    stop = 1'b0;

    // Asynchronous reset in the middle of a scan at w=15.
    start = 1'b1; dwell = 4'd0; loop = 1'b0; dir = 1'b0;
    for (int k = 0; k <= 15; k++) exp_q.push_back(mk(1, 6'(k), 0, 0, 1));
    run_q("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check_obs("mid_reset", mk(0, 6'd0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(mk(0, 6'd0, 0, 0, 0));
    run_q("after_reset");
    start = 1'b1; dwell = 4'd0; loop = 1'b0; dir = 1'b0;
    push_scan_once(0, 1'b0);
    run_q("restart");

`ifdef SEQ_DOWN_EN
    start = 1'b1; dwell = 4'd0; loop = 1'b0; dir = 1'b1;
    push_scan_once(0, 1'b1);
    run_q("down_scan");
    start = 1'b1; dwell = 4'd0; loop = 1'b1; dir = 1'b1;
    push_pass(0, 1'b1, 1'b0);
    exp_q.push_back(mk(1, 6'd63, 0, 1, 1));
    exp_q.push_back(mk(1, 6'd62, 0, 0, 1));
    run_q("down_loop");
    stop = 1'b1;
    exp_q.push_back(mk(0, 6'd62, 0, 0, 0));
    run_q("down_stop");
    stop = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
